// File: rtl/txpause_sched_pkg.sv
// rtl/txpause_sched_pkg.sv - MAC control PAUSE constants shared by TX scheduler and RX pause detector
package txpause_sched_pkg;

  localparam logic [47:0] PAUSE_DA        = 48'h01_00_00_C2_80_01;  // 01-80-C2-00-00-01, byte 0 in [7:0]
  localparam logic [15:0] PAUSE_ETHERTYPE = 16'h8808;
  localparam logic [15:0] PAUSE_OPCODE    = 16'h0001;
  localparam int          PAUSE_BEATS     = 8;
  localparam logic [7:0]  LAST_TKEEP      = 8'h0F;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_USER     = 2'd1,
    ST_PAUSE_TX = 2'd2
  } state_t;

endpackage

// File: rtl/txpause_gen.sv
// rtl/txpause_gen.sv - combinational PAUSE frame beat formatter (little-endian byte lanes)
module txpause_gen #(
  parameter int         PAUSE_BEATS = txpause_sched_pkg::PAUSE_BEATS,
  parameter logic [7:0] LAST_TKEEP  = txpause_sched_pkg::LAST_TKEEP,
  parameter int         BW          = 3
) (
  input  logic [BW-1:0] beat,
  input  logic [47:0]   src_mac,
  input  logic [15:0]   quanta,
  output logic [63:0]   tdata,
  output logic [7:0]    tkeep,
  output logic          tlast
);
  import txpause_sched_pkg::*;

  // Ethertype and opcode go out most-significant byte first on the wire
  always_comb begin
    tdata = '0;
    if (beat == BW'(0))
      tdata = {src_mac[15:0], PAUSE_DA};
    else if (beat == BW'(1))
      tdata = {PAUSE_OPCODE[7:0], PAUSE_OPCODE[15:8],
               PAUSE_ETHERTYPE[7:0], PAUSE_ETHERTYPE[15:8], src_mac[47:16]};
    else if (beat == BW'(2))
      tdata = {48'h0, quanta[7:0], quanta[15:8]};
  end

  assign tlast = (beat == BW'(PAUSE_BEATS - 1));
  assign tkeep = tlast ? LAST_TKEEP : 8'hFF;

endmodule

// File: rtl/txpause_sched.sv
// rtl/txpause_sched.sv - TX arbiter inserting XOFF/XON PAUSE frames between user frames
module txpause_sched #(
  parameter int         PAUSE_BEATS = txpause_sched_pkg::PAUSE_BEATS,
  parameter logic [7:0] LAST_TKEEP  = txpause_sched_pkg::LAST_TKEEP
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        cfg_tx_pause_enable,
  input  logic [15:0] cfg_pause_quanta,
  input  logic [15:0] cfg_refresh_cycles,
  input  logic [47:0] cfg_src_mac,
  input  logic        rx_pause_active,
  input  logic        xoff_req,
  input  logic [63:0] s_tdata,
  input  logic [7:0]  s_tkeep,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  input  logic        s_tuser,
  output logic        s_tready,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        m_tuser,
  input  logic        m_tready,
  output logic        tx_paused,
  output logic        pause_sent
);
  import txpause_sched_pkg::*;

  localparam int BW = (PAUSE_BEATS > 1) ? $clog2(PAUSE_BEATS) : 1;

  state_t        state, state_nxt;
  logic [BW-1:0] beat;
  logic          xoff_q;
  logic          pend;
  logic [15:0]   pend_quanta;
  logic [15:0]   cur_quanta;
  logic [15:0]   refresh_cnt;
  logic          pend_eff, start_pause, pause_acc, refresh_hit;
  logic          xoff_rise, xoff_fall;
  logic [63:0]   gen_tdata;
  logic [7:0]    gen_tkeep;
  logic          gen_tlast;

  assign xoff_rise   = xoff_req & ~xoff_q;
  assign xoff_fall   = ~xoff_req & xoff_q;
  assign refresh_hit = (cfg_refresh_cycles != 16'd0) && (refresh_cnt == cfg_refresh_cycles - 16'd1);
  assign pend_eff    = pend & cfg_tx_pause_enable;

  txpause_gen #(.PAUSE_BEATS(PAUSE_BEATS), .LAST_TKEEP(LAST_TKEEP), .BW(BW)) u_gen (
    .beat    (beat),
    .src_mac (cfg_src_mac),
    .quanta  (cur_quanta),
    .tdata   (gen_tdata),
    .tkeep   (gen_tkeep),
    .tlast   (gen_tlast)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      beat        <= '0;
      xoff_q      <= 1'b0;
      pend        <= 1'b0;
      pend_quanta <= '0;
      cur_quanta  <= '0;
      refresh_cnt <= '0;
    end else begin
      state  <= state_nxt;
      xoff_q <= xoff_req;
      if (start_pause)
        cur_quanta <= pend_quanta;
      if (pause_acc)
        beat <= gen_tlast ? '0 : beat + BW'(1);
      // Later events overwrite the single pending slot; a start in the same cycle still re-arms it
      if (!cfg_tx_pause_enable) begin
        pend        <= 1'b0;
        refresh_cnt <= '0;
      end else begin
        if (start_pause)
          pend <= 1'b0;
        if (xoff_rise) begin
          pend        <= 1'b1;
          pend_quanta <= cfg_pause_quanta;
          refresh_cnt <= '0;
        end else if (xoff_fall) begin
          pend        <= 1'b1;
          pend_quanta <= '0;
          refresh_cnt <= '0;
        end else if (xoff_req) begin
          if (refresh_hit) begin
            pend        <= 1'b1;
            pend_quanta <= cfg_pause_quanta;
            refresh_cnt <= '0;
          end else begin
            refresh_cnt <= refresh_cnt + 16'd1;
          end
        end else begin
          refresh_cnt <= '0;
        end
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    s_tready    = 1'b0;
    m_tdata     = '0;
    m_tkeep     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tuser     = 1'b0;
    tx_paused   = 1'b0;
    pause_sent  = 1'b0;
    start_pause = 1'b0;
    pause_acc   = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_paused = rx_pause_active;
        if (pend_eff) begin
          state_nxt   = ST_PAUSE_TX;
          start_pause = 1'b1;
        end else if (s_tvalid && !rx_pause_active) begin
          state_nxt = ST_USER;
        end
      end
      ST_USER: begin
        m_tdata  = s_tdata;
        m_tkeep  = s_tkeep;
        m_tvalid = s_tvalid;
        m_tlast  = s_tlast;
        m_tuser  = s_tuser;
        s_tready = m_tready;
        if (s_tvalid && m_tready && s_tlast)
          state_nxt = ST_IDLE;
      end
      ST_PAUSE_TX: begin
        m_tdata   = gen_tdata;
        m_tkeep   = gen_tkeep;
        m_tvalid  = 1'b1;
        m_tlast   = gen_tlast;
        m_tuser   = 1'b1;
        pause_acc = m_tready;
        if (m_tready && gen_tlast) begin
          pause_sent = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_txpause_sched.sv
// tb/tb_txpause_sched.sv - directed bench with byte-level PAUSE frame model and per-cycle monitor
module tb_txpause_sched;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cfg_tx_pause_enable;
  logic [15:0] cfg_pause_quanta;
  logic [15:0] cfg_refresh_cycles;
  logic [47:0] cfg_src_mac;
  logic        rx_pause_active;
  logic        xoff_req;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tuser;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tuser;
  logic        m_tready;
  logic        tx_paused;
  logic        pause_sent;

  always #5 clk = ~clk;

  txpause_sched dut (
    .clk                 (clk),
    .aresetn             (aresetn),
    .cfg_tx_pause_enable (cfg_tx_pause_enable),
    .cfg_pause_quanta    (cfg_pause_quanta),
    .cfg_refresh_cycles  (cfg_refresh_cycles),
    .cfg_src_mac         (cfg_src_mac),
    .rx_pause_active     (rx_pause_active),
    .xoff_req            (xoff_req),
    .s_tdata             (s_tdata),
    .s_tkeep             (s_tkeep),
    .s_tvalid            (s_tvalid),
    .s_tlast             (s_tlast),
    .s_tuser             (s_tuser),
    .s_tready            (s_tready),
    .m_tdata             (m_tdata),
    .m_tkeep             (m_tkeep),
    .m_tvalid            (m_tvalid),
    .m_tlast             (m_tlast),
    .m_tuser             (m_tuser),
    .m_tready            (m_tready),
    .tx_paused           (tx_paused),
    .pause_sent          (pause_sent)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The PAUSE frame as a 60-byte array, sliced into 8-byte beats
  function automatic logic [63:0] model_beat(input int idx, input logic [15:0] q, input logic [47:0] sa);
    logic [7:0]  fb [0:63];
    logic [63:0] r;
    for (int i = 0; i < 64; i++) fb[i] = 8'h00;
    fb[0] = 8'h01; fb[1] = 8'h80; fb[2] = 8'hC2; fb[3] = 8'h00; fb[4] = 8'h00; fb[5] = 8'h01;
    for (int i = 0; i < 6; i++) fb[6+i] = sa[8*i +: 8];
    fb[12] = 8'h88; fb[13] = 8'h08; fb[14] = 8'h00; fb[15] = 8'h01;
    fb[16] = q[15:8]; fb[17] = q[7:0];
    for (int i = 0; i < 8; i++) r[8*i +: 8] = fb[idx*8+i];
    return r;
  endfunction

  function automatic logic [7:0] model_keep(input int idx);
    int nb;
    nb = 60 - 8*idx;
    return (nb >= 8) ? 8'hFF : 8'((1 << nb) - 1);
  endfunction

  logic [15:0] exp_q[$];
  logic [72:0] exp_user[$];
  logic [63:0] cap [0:7];
  logic [7:0]  capk [0:7];
  int          pidx = 0;
  int          cyc = 0;
  int          n_sent = 0;
  int          n_pframes = 0;
  int          n_pbeats = 0;
  int          last_user_cyc = 0;
  int          first_pause_cyc = 0;
  logic        in_frame = 1'b0;
  logic        sready_seen = 1'b0;
  logic        sready_gap = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;

  always @(negedge clk) begin
    cyc++;
    if (!aresetn) begin
      if (pidx != 0) begin
        void'(exp_q.pop_front());
        pidx = 0;
      end
      in_frame   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("pause_sent_pulse", pause_sent, m_tvalid && m_tready && m_tuser && m_tlast);
      if (pause_sent) n_sent++;
      if (prev_stall) begin
        check("stall_valid", m_tvalid, 1'b1);
        check("stall_data", m_tdata, prev_data);
        check("stall_keep", m_tkeep, prev_keep);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_keep  = m_tkeep;
      if (s_tready) begin
        sready_seen = 1'b1;
        check("pass_valid", m_tvalid, s_tvalid);
        check("pass_data", m_tdata, s_tdata);
        check("pass_ready", m_tready, 1'b1);
      end
      if (m_tvalid && m_tuser) begin
        check("pause_blocks_user", s_tready, 1'b0);
        if (!in_frame) begin
          in_frame        = 1'b1;
          first_pause_cyc = cyc;
          sready_gap      = sready_seen;
        end
      end
      if (m_tvalid && m_tready) begin
        if (m_tuser) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pause_beat: got data %h with no frame expected", m_tdata);
          end else begin
            check("pause_data", m_tdata, model_beat(pidx, exp_q[0], cfg_src_mac));
            check("pause_keep", m_tkeep, model_keep(pidx));
            check("pause_last", m_tlast, pidx == 7);
            cap[pidx]  = m_tdata;
            capk[pidx] = m_tkeep;
            n_pbeats++;
            if (pidx == 7) begin
              void'(exp_q.pop_front());
              pidx     = 0;
              in_frame = 1'b0;
              n_pframes++;
            end else begin
              pidx++;
            end
          end
        end else begin
          if (exp_user.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_user_beat: got data %h with no beat expected", m_tdata);
          end else begin
            check("user_beat", {m_tlast, m_tkeep, m_tdata}, exp_user.pop_front());
            if (m_tlast) begin
              last_user_cyc = cyc;
              sready_seen   = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || pidx != 0) && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_done_in_time"}, n < bound, 1'b1);
  endtask

  task automatic send_user(input int nbeats, input logic [63:0] base);
    for (int i = 0; i < nbeats; i++) begin
      int g = 0;
      s_tvalid = 1'b1;
      s_tdata  = base + 64'(i);
      s_tkeep  = 8'hFF;
      s_tlast  = (i == nbeats - 1);
      exp_user.push_back({s_tlast, s_tkeep, s_tdata});
      do begin
        @(negedge clk);
        g++;
      end while (!s_tready && g < 100);
      check("user_beat_accepted", s_tready, 1'b1);
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent0, pf0, pb0, g;
    aresetn             = 1'b0;
    cfg_tx_pause_enable = 1'b1;
    cfg_pause_quanta    = 16'h1234;
    cfg_refresh_cycles  = 16'd0;
    cfg_src_mac         = 48'hA5A4A3A2A1A0;
    rx_pause_active     = 1'b0;
    xoff_req            = 1'b0;
    s_tdata             = '0;
    s_tkeep             = '0;
    s_tvalid            = 1'b0;
    s_tlast             = 1'b0;
    s_tuser             = 1'b0;
    m_tready            = 1'b1;
    #3;
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_pause_sent", pause_sent, 1'b0);
    check("rst_tx_paused", tx_paused, 1'b0);
    repeat (3) @(posedge clk);
    #3 aresetn = 1'b1;
    repeat (2) tick();

    // XOFF with quanta 1234, then XON
    sent0 = n_sent;
    exp_q.push_back(16'h1234);
    xoff_req = 1'b1;
    wait_done("t1_xoff", 40);
    check("t1_beat0", cap[0], 64'hA1A0_0100_00C2_8001);
    check("t1_beat1", cap[1], 64'h0100_0888_A5A4_A3A2);
    check("t1_beat2_quanta", {48'h0, cap[2][15:0]}, 64'h3412);
    check("t1_beat7_keep", capk[7], 8'h0F);
    check("t1_one_pulse", n_sent - sent0, 1);
    exp_q.push_back(16'h0000);
    xoff_req = 1'b0;
    wait_done("t1_xon", 40);

    // XOFF arriving mid user frame waits for the frame plus one bubble
    fork
      send_user(10, 64'h1000);
      begin
        repeat (4) tick();
        exp_q.push_back(16'h1234);
        xoff_req = 1'b1;
      end
    join
    wait_done("t2_xoff", 40);
    check("t2_user_complete", exp_user.size(), 0);
    check("t2_gap", first_pause_cyc - last_user_cyc, 2);
    check("t2_no_sready_gap", sready_gap, 1'b0);
    exp_q.push_back(16'h0000);
    xoff_req = 1'b0;
    wait_done("t2_xon", 40);

    // Refresh every 100 cycles over 350 high cycles
    pf0 = n_pframes;
    cfg_pause_quanta   = 16'h00FF;
    cfg_refresh_cycles = 16'd100;
    repeat (4) exp_q.push_back(16'h00FF);
    exp_q.push_back(16'h0000);
    xoff_req = 1'b1;
    repeat (350) tick();
    xoff_req = 1'b0;
    wait_done("t3_refresh", 60);
    check("t3_frames", n_pframes - pf0, 5);
    cfg_refresh_cycles = 16'd0;

    // Link partner pause blocks user traffic but not PAUSE frames
    rx_pause_active = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 64'hCAFE_F00D_0000_0001;
    s_tkeep  = 8'hFF;
    s_tlast  = 1'b1;
    exp_user.push_back({1'b1, 8'hFF, 64'hCAFE_F00D_0000_0001});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_blocked_sready", s_tready, 1'b0);
      check("t4_tx_paused", tx_paused, 1'b1);
    end
    tick();
    cfg_pause_quanta = 16'hBEEF;
    exp_q.push_back(16'hBEEF);
    xoff_req = 1'b1;
    wait_done("t4_xoff", 40);
    exp_q.push_back(16'h0000);
    xoff_req = 1'b0;
    wait_done("t4_xon", 40);
    check("t4_user_held", exp_user.size(), 1);
    rx_pause_active = 1'b0;
    @(negedge clk);
    check("t4_resume_bubble", s_tready, 1'b0);
    @(negedge clk);
    check("t4_resume_sready", s_tready, 1'b1);
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    tick();
    check("t4_user_sent", exp_user.size(), 0);

    // Random backpressure across a PAUSE frame
    pb0 = n_pbeats;
    pf0 = n_pframes;
    cfg_pause_quanta = 16'h5678;
    exp_q.push_back(16'h5678);
    xoff_req = 1'b1;
    g = 0;
    while ((exp_q.size() != 0 || pidx != 0) && g < 300) begin
      tick();
      m_tready = (g % 4 == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
      g++;
    end
    check("t5_done_in_time", g < 300, 1'b1);
    m_tready = 1'b1;
    check("t5_beats", n_pbeats - pb0, 8);
    check("t5_frames", n_pframes - pf0, 1);
    tick();
    exp_q.push_back(16'h0000);
    xoff_req = 1'b0;
    wait_done("t5_xon", 40);

    // Reset in the middle of a PAUSE frame drops it and the pending XON
    cfg_pause_quanta = 16'h00AA;
    exp_q.push_back(16'h00AA);
    xoff_req = 1'b1;
    g = 0;
    do begin
      @(posedge clk);
      g++;
    end while (pidx == 0 && g < 40);
    #1 xoff_req = 1'b0;
    while (pidx != 4 && g < 80) begin
      @(posedge clk);
      g++;
    end
    check("t6_reached_beat4", pidx, 4);
    #2 aresetn = 1'b0;
    #1;
    check("t6_rst_m_tvalid", m_tvalid, 1'b0);
    check("t6_rst_s_tready", s_tready, 1'b0);
    check("t6_rst_pause_sent", pause_sent, 1'b0);
    repeat (2) @(posedge clk);
    #3 aresetn = 1'b1;
    pf0 = n_pframes;
    repeat (40) tick();
    check("t6_no_frame_after_reset", n_pframes - pf0, 0);
    check("t6_queue_empty", exp_q.size(), 0);

    check("total_pause_sent", n_sent, 13);
    check("user_queue_empty", exp_user.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
